// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if -- signal bundle between a frame source/DAC side and
// the VGA timing controller.
//
// Optional feature macro: VGA_TEST_PATTERN_EN (adds pattern_en).
//
// Signals
//   run          master -> slave  1 = generate timing, 0 = idle
//   rgb_in       master -> slave  12-bit pixel {R,G,B} from the frame source
//   pattern_en   master -> slave  selects built-in colour bars (macro only)
//   pix_tick     slave -> master  one-cycle pulse per pixel slot
//   hsync/vsync  slave -> master  sync pulses, polarity per SYNC_POL
//   video_on     slave -> master  inside visible area
//   px_x/px_y    slave -> master  current pixel/line counters (10 bits)
//   frame_start  slave -> master  pulse on the tick at pixel (0,0)
//   rgb_out      slave -> master  12-bit pixel to the DAC
interface vga_timing_ctrl_if;
   logic        run;
   logic [11:0] rgb_in;
`ifdef VGA_TEST_PATTERN_EN
   logic        pattern_en;
`endif
   logic        pix_tick;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic [9:0]  px_x;
   logic [9:0]  px_y;
   logic        frame_start;
   logic [11:0] rgb_out;

   modport master (
`ifdef VGA_TEST_PATTERN_EN
      output pattern_en,
`endif
      output run, rgb_in,
      input  pix_tick, hsync, vsync, video_on, px_x, px_y, frame_start, rgb_out
   );

   modport slave (
`ifdef VGA_TEST_PATTERN_EN
      input  pattern_en,
`endif
      input  run, rgb_in,
      output pix_tick, hsync, vsync, video_on, px_x, px_y, frame_start, rgb_out
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl -- VGA raster timing generator with pixel prescaler,
// horizontal/vertical counters and per-axis porch/sync FSMs.
//
// Optional feature macro: VGA_TEST_PATTERN_EN (8 vertical colour bars
// selected by vif.pattern_en).
//
// Ports
//   clk_in    system clock, all state changes on its rising edge
//   rst_n_in  asynchronous active-low reset
//   vif       vga_timing_ctrl_if.slave (run, rgb_in, [pattern_en] in;
//             pix_tick, hsync, vsync, video_on, px_x, px_y, frame_start,
//             rgb_out out)
//
// States (both axes share the same shape)
//   state            | meaning
//   H_ACTIVE/V_ACTIVE | visible pixels / lines
//   H_FRONT/V_FRONT   | front porch
//   H_SYNC_S/V_SYNC_S | sync pulse asserted
//   H_BACK/V_BACK     | back porch
module vga_timing_ctrl #(
   parameter int DIV    = 2,
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input logic              clk_in,
   input logic              rst_n_in,
   vga_timing_ctrl_if.slave vif
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0] P_LAST     = PW'(DIV - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_VIS - 1);
   localparam logic [HW-1:0] H_FP_END   = HW'(H_VIS + H_FP - 1);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_VIS - 1);
   localparam logic [VW-1:0] V_FP_END   = VW'(V_VIS + V_FP - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);

   typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC_S, H_BACK} h_state_t;
   typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC_S, V_BACK} v_state_t;

   h_state_t      h_state, h_state_nxt;
   v_state_t      v_state, v_state_nxt;
   logic [PW-1:0] presc;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          active;     // run was seen high on the previous edge
   logic          rst_done;   // blanks rgb_out until the first edge after reset
   logic          pix_tick;
   logic          h_wrap;
   logic          video_on;
   logic [11:0]   rgb_sel;

   // The prescaler holds at 0 on the edge that first sees run, so the first
   // tick lands DIV edges after run rises and always carries frame_start.
   assign pix_tick = active && (presc == P_LAST);
   assign h_wrap   = pix_tick && (h_cnt == H_LAST);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         presc    <= '0;
         h_cnt    <= '0;
         v_cnt    <= '0;
         h_state  <= H_ACTIVE;
         v_state  <= V_ACTIVE;
         active   <= 1'b0;
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (!vif.run) begin
            presc   <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_state <= H_ACTIVE;
            v_state <= V_ACTIVE;
            active  <= 1'b0;
         end else begin
            active  <= 1'b1;
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
            if (active)
               presc <= (presc == P_LAST) ? '0 : presc + 1'b1;
            if (pix_tick)
               h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
            if (h_wrap)
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      h_state_nxt = h_state;
      if (pix_tick) begin
         case (h_state)
            H_ACTIVE: if (h_cnt == H_VIS_END)  h_state_nxt = H_FRONT;
            H_FRONT:  if (h_cnt == H_FP_END)   h_state_nxt = H_SYNC_S;
            H_SYNC_S: if (h_cnt == H_SYNC_END) h_state_nxt = H_BACK;
            H_BACK:   if (h_cnt == H_LAST)     h_state_nxt = H_ACTIVE;
            default:  h_state_nxt = H_ACTIVE;
         endcase
      end
   end

   always_comb begin
      v_state_nxt = v_state;
      if (h_wrap) begin
         case (v_state)
            V_ACTIVE: if (v_cnt == V_VIS_END)  v_state_nxt = V_FRONT;
            V_FRONT:  if (v_cnt == V_FP_END)   v_state_nxt = V_SYNC_S;
            V_SYNC_S: if (v_cnt == V_SYNC_END) v_state_nxt = V_BACK;
            V_BACK:   if (v_cnt == V_LAST)     v_state_nxt = V_ACTIVE;
            default:  v_state_nxt = V_ACTIVE;
         endcase
      end
   end

   assign video_on = (h_state == H_ACTIVE) && (v_state == V_ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0]  bar_idx;
   logic [11:0] bar_rgb;

   assign bar_idx = 3'((32'(h_cnt) * 32'd8) / 32'(H_VIS));

   always_comb begin
      bar_rgb = 12'h000;
      case (bar_idx)
         3'd0:    bar_rgb = 12'hFFF;
         3'd1:    bar_rgb = 12'hFF0;
         3'd2:    bar_rgb = 12'h0FF;
         3'd3:    bar_rgb = 12'h0F0;
         3'd4:    bar_rgb = 12'hF0F;
         3'd5:    bar_rgb = 12'hF00;
         3'd6:    bar_rgb = 12'h00F;
         default: bar_rgb = 12'h000;
      endcase
   end

   assign rgb_sel = vif.pattern_en ? bar_rgb : vif.rgb_in;
`else
   assign rgb_sel = vif.rgb_in;
`endif

   assign vif.pix_tick    = pix_tick;
   assign vif.hsync       = (h_state == H_SYNC_S) ? SYNC_POL : ~SYNC_POL;
   assign vif.vsync       = (v_state == V_SYNC_S) ? SYNC_POL : ~SYNC_POL;
   assign vif.video_on    = video_on;
   assign vif.px_x        = 10'(h_cnt);
   assign vif.px_y        = 10'(v_cnt);
   assign vif.frame_start = pix_tick && (h_cnt == '0) && (v_cnt == '0);
   // video_on reads 1 in reset, so rgb_out is additionally held low there.
   assign vif.rgb_out     = (video_on && rst_done) ? rgb_sel : 12'h000;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl -- checks two vga_timing_ctrl instances (default
// horizontal geometry with short frames at DIV=2, and a tiny 10x6 raster at
// DIV=1 with active-high syncs) against an arithmetic raster model.
module tb_vga_timing_ctrl;

   localparam int A_DIV = 2;
   localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
   localparam int A_VV = 4,   A_VF = 1,  A_VS = 2,  A_VB = 2;
   localparam bit A_POL = 1'b0;
   localparam int B_DIV = 1;
   localparam int B_HV = 4, B_HF = 2, B_HS = 2, B_HB = 2;
   localparam int B_VV = 2, B_VF = 1, B_VS = 2, B_VB = 1;
   localparam bit B_POL = 1'b1;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b1;
   logic        run    = 1'b0;
   logic [11:0] rgb_in = 12'hABC;
   logic        pat    = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: edges since run was first sampled high.
   int m_k      = 0;
   bit m_active = 1'b0;
   bit m_rdone  = 1'b0;

   typedef struct {
      bit          tick;
      bit          hs;
      bit          vs;
      bit          von;
      bit          fs;
      int          x;
      int          y;
      logic [11:0] rgb;
   } exp_t;

   always #5 clk_in = ~clk_in;

   vga_timing_ctrl_if vif_a ();
   vga_timing_ctrl_if vif_b ();

   assign vif_a.run    = run;
   assign vif_a.rgb_in = rgb_in;
   assign vif_b.run    = run;
   assign vif_b.rgb_in = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
   assign vif_a.pattern_en = pat;
   assign vif_b.pattern_en = pat;
`endif

   vga_timing_ctrl #(
      .DIV(A_DIV), .H_VIS(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_VIS(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .SYNC_POL(A_POL)
   ) u_dut_a (
      .clk_in  (clk_in),
      .rst_n_in(rst_n),
      .vif     (vif_a)
   );

   vga_timing_ctrl #(
      .DIV(B_DIV), .H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .SYNC_POL(B_POL)
   ) u_dut_b (
      .clk_in  (clk_in),
      .rst_n_in(rst_n),
      .vif     (vif_b)
   );

   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_rdone  <= 1'b0;
      end else begin
         m_rdone <= 1'b1;
         if (run) begin
            m_k      <= m_active ? m_k + 1 : 0;
            m_active <= 1'b1;
         end else begin
            m_k      <= 0;
            m_active <= 1'b0;
         end
      end
   end

   function automatic logic [11:0] bar_colour(int x, int hv);
      case ((x * 8) / hv)
         0:       return 12'hFFF;
         1:       return 12'hFF0;
         2:       return 12'h0FF;
         3:       return 12'h0F0;
         4:       return 12'hF0F;
         5:       return 12'hF00;
         6:       return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   // Pixel index = elapsed edges / DIV; position follows by div/mod.
   function automatic exp_t model(int div, int hv, int hf, int hsw, int hb,
                                  int vv, int vf, int vsw, int vb, bit pol);
      exp_t e;
      int   p;
      int   ht;
      int   vt;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      if (!m_active) begin
         e.x = 0; e.y = 0; e.tick = 1'b0; e.fs = 1'b0;
         e.hs = !pol; e.vs = !pol; e.von = 1'b1;
      end else begin
         p      = m_k / div;
         e.x    = p % ht;
         e.y    = (p / ht) % vt;
         e.tick = ((m_k + 1) % div) == 0;
         e.hs   = (e.x >= hv + hf && e.x < hv + hf + hsw) ? pol : !pol;
         e.vs   = (e.y >= vv + vf && e.y < vv + vf + vsw) ? pol : !pol;
         e.von  = (e.x < hv) && (e.y < vv);
         e.fs   = e.tick && e.x == 0 && e.y == 0;
      end
      if (!m_rdone || !e.von) e.rgb = 12'h000;
      else if (pat)           e.rgb = bar_colour(e.x, hv);
      else                    e.rgb = rgb_in;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string tag, input exp_t e, input logic tick,
                            input logic hs, input logic vs, input logic von,
                            input logic fs, input logic [9:0] x,
                            input logic [9:0] y, input logic [11:0] rgb);
      chk({tag, "_pix_tick"},    int'(tick), int'(e.tick));
      chk({tag, "_hsync"},       int'(hs),   int'(e.hs));
      chk({tag, "_vsync"},       int'(vs),   int'(e.vs));
      chk({tag, "_video_on"},    int'(von),  int'(e.von));
      chk({tag, "_frame_start"}, int'(fs),   int'(e.fs));
      chk({tag, "_px_x"},        int'(x),    e.x);
      chk({tag, "_px_y"},        int'(y),    e.y);
      chk({tag, "_rgb_out"},     int'(rgb),  int'(e.rgb));
   endtask

   always @(negedge clk_in) begin
      check_dut("a", model(A_DIV, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_POL),
                vif_a.pix_tick, vif_a.hsync, vif_a.vsync, vif_a.video_on,
                vif_a.frame_start, vif_a.px_x, vif_a.px_y, vif_a.rgb_out);
      check_dut("b", model(B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_POL),
                vif_b.pix_tick, vif_b.hsync, vif_b.vsync, vif_b.video_on,
                vif_b.frame_start, vif_b.px_x, vif_b.px_y, vif_b.rgb_out);
   end

   // Returns at the negedge following the edge where the model reaches k.
   task automatic wait_k(input int target);
      int guard;
      guard = 0;
      @(negedge clk_in);
      while (!(m_active && m_k == target) && guard < 60000) begin
         @(negedge clk_in);
         guard++;
      end
      n_tests++;
      if (guard >= 60000) begin
         n_fail++;
         $display("FAIL wait_k: got timeout expected k=%0d", target);
      end
   endtask

   int idle_cnt;
   int rst_cnt;

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_a_px_x",     int'(vif_a.px_x),        0);
      chk("rst_a_video_on", int'(vif_a.video_on),    1);
      chk("rst_a_rgb_out",  int'(vif_a.rgb_out),     0);
      chk("rst_a_hsync",    int'(vif_a.hsync),       1);
      chk("rst_b_vsync",    int'(vif_b.vsync),       0);
      chk("rst_b_pix_tick", int'(vif_b.pix_tick),    0);

      @(posedge clk_in); #2 rst_n = 1'b1;
      @(posedge clk_in); #1 run = 1'b1;

      wait_k(0);
      chk("k0_a_pix_tick",    int'(vif_a.pix_tick),    0);
      chk("k0_b_pix_tick",    int'(vif_b.pix_tick),    1);
      chk("k0_b_frame_start", int'(vif_b.frame_start), 1);
      wait_k(1);
      chk("k1_a_pix_tick",    int'(vif_a.pix_tick),    1);
      chk("k1_a_frame_start", int'(vif_a.frame_start), 1);
      chk("k1_b_px_x",        int'(vif_b.px_x),        1);
      wait_k(5);   chk("b_hsync_pre",  int'(vif_b.hsync), 0);
      wait_k(6);   chk("b_hsync_on",   int'(vif_b.hsync), 1);
      wait_k(9);   chk("b_px_x_9",     int'(vif_b.px_x),  9);
      wait_k(10);
      chk("b_wrap_px_x", int'(vif_b.px_x), 0);
      chk("b_wrap_px_y", int'(vif_b.px_y), 1);
      wait_k(59);  chk("b_last_px_y",  int'(vif_b.px_y),  5);
      wait_k(60);
      chk("b_frame_px_y",    int'(vif_b.px_y),        0);
      chk("b_frame_start_2", int'(vif_b.frame_start), 1);
      wait_k(1279);
      chk("a_x639_px_x",  int'(vif_a.px_x),    639);
      chk("a_x639_rgb",   int'(vif_a.rgb_out), 12'hABC);
      wait_k(1280);
      chk("a_x640_rgb",   int'(vif_a.rgb_out),  0);
      chk("a_x640_von",   int'(vif_a.video_on), 0);
      wait_k(1311); chk("a_hsync_655", int'(vif_a.hsync), 1);
      wait_k(1312);
      chk("a_hsync_656",  int'(vif_a.hsync), 0);
      chk("a_px_x_656",   int'(vif_a.px_x),  656);
      wait_k(1503); chk("a_hsync_751", int'(vif_a.hsync), 0);
      wait_k(1504); chk("a_hsync_752", int'(vif_a.hsync), 1);
      wait_k(1600);
      chk("a_line1_px_x", int'(vif_a.px_x), 0);
      chk("a_line1_px_y", int'(vif_a.px_y), 1);
      wait_k(2912); chk("a_hsync_period", int'(vif_a.hsync), 0);
      wait_k(4800); chk("a_y3_rgb", int'(vif_a.rgb_out), 12'hABC);
      wait_k(6400);
      chk("a_y4_px_y", int'(vif_a.px_y),    4);
      chk("a_y4_rgb",  int'(vif_a.rgb_out), 0);
      wait_k(7999);  chk("a_vsync_pre",  int'(vif_a.vsync), 1);
      wait_k(8000);  chk("a_vsync_on",   int'(vif_a.vsync), 0);
      wait_k(11199); chk("a_vsync_last", int'(vif_a.vsync), 0);
      wait_k(11200); chk("a_vsync_off",  int'(vif_a.vsync), 1);
      wait_k(14400); chk("a_fs_pre",     int'(vif_a.frame_start), 0);
      wait_k(14401); chk("a_fs_frame2",  int'(vif_a.frame_start), 1);
      wait_k(22400); chk("a_vsync_period", int'(vif_a.vsync), 0);
      wait_k(28801); chk("a_fs_frame3",  int'(vif_a.frame_start), 1);
      wait_k(33800);
      chk("a_mid_px_y", int'(vif_a.px_y), 3);
      chk("a_mid_px_x", int'(vif_a.px_x), 100);

      run = 1'b0;
      @(negedge clk_in);
      chk("drop_a_px_x",     int'(vif_a.px_x),     0);
      chk("drop_a_px_y",     int'(vif_a.px_y),     0);
      chk("drop_a_pix_tick", int'(vif_a.pix_tick), 0);
      repeat (3) @(negedge clk_in);
      run = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      pat = 1'b1;
`endif
      wait_k(0); chk("rerun_a_fs0", int'(vif_a.frame_start), 0);
      wait_k(1); chk("rerun_a_fs1", int'(vif_a.frame_start), 1);
`ifdef VGA_TEST_PATTERN_EN
      chk("pat_x0",   int'(vif_a.rgb_out), 12'hFFF);
      wait_k(161);  chk("pat_x80",  int'(vif_a.rgb_out), 12'hFF0);
      wait_k(1279); chk("pat_x639", int'(vif_a.rgb_out), 12'h000);
      pat = 1'b0;
`endif
      wait_k(1500);
      @(posedge clk_in); #2 rst_n = 1'b0;
      #1;
      chk("arst_a_px_x",     int'(vif_a.px_x),     0);
      chk("arst_a_pix_tick", int'(vif_a.pix_tick), 0);
      chk("arst_a_hsync",    int'(vif_a.hsync),    1);
      chk("arst_a_rgb_out",  int'(vif_a.rgb_out),  0);
      chk("arst_a_video_on", int'(vif_a.video_on), 1);
      repeat (3) @(posedge clk_in);
      #2 rst_n = 1'b1;

      idle_cnt = 0;
      rst_cnt  = 0;
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk_in);
         #1;
         rgb_in = 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
         if ($urandom_range(0, 99) == 0) pat = ~pat;
`endif
         if (idle_cnt > 0) begin
            idle_cnt--;
            run = 1'b0;
         end else begin
            run = 1'b1;
            if ($urandom_range(0, 1999) == 0) idle_cnt = $urandom_range(1, 5);
         end
         #1;
         if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) rst_n = 1'b1;
         end else if ($urandom_range(0, 2999) == 0) begin
            rst_n   = 1'b0;
            rst_cnt = $urandom_range(1, 3);
         end
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk_in);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
